// File: rtl/pwm_compare.sv
// PWM comparator: registered pwm_out/period_start lag count by 1 cycle; duty shadow loads on counter wrap.
// Duty handshake stalls (duty_ready=0) while a shadow value waits for the next wrap. Optional PWM_INVERT_EN inverts the output.
module pwm_compare #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_start,
    output logic             running
);

`ifdef PWM_INVERT_EN
    localparam logic IDLE_LVL = 1'b1;
`else
    localparam logic IDLE_LVL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] duty_active;
    logic [WIDTH-1:0] eff;
    logic             pending_full;
    logic             wrap;
    logic             hi;
    logic             drive_nxt;
    logic             ps_nxt;

    // A decrease in count marks a wrap, so increments that skip zero are still caught.
    assign wrap       = (count < count_q);
    assign eff        = (wrap && pending_full) ? pending : duty_active;
    assign hi         = (count < eff);
    assign duty_ready = !pending_full;
    assign running    = (state == RUN) || (state == DRAIN);

    always_comb begin
        state_nxt = state;
        drive_nxt = 1'b0;
        ps_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (en) state_nxt = ARM;
            end
            ARM: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (wrap) begin
                    state_nxt = RUN;
                    drive_nxt = hi;
                    ps_nxt    = 1'b1;
                end
            end
            RUN: begin
                drive_nxt = hi;
                ps_nxt    = wrap;
                if (!en) state_nxt = DRAIN;
            end
            DRAIN: begin
                // Re-enable before the wrap resumes RUN without losing the period.
                if (en) begin
                    state_nxt = RUN;
                    drive_nxt = hi;
                    ps_nxt    = wrap;
                end else if (wrap) begin
                    state_nxt = IDLE;
                end else begin
                    drive_nxt = hi;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            count_q      <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            duty_active  <= '0;
            pwm_out      <= IDLE_LVL;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            count_q      <= count;
            pwm_out      <= drive_nxt ^ IDLE_LVL;
            period_start <= ps_nxt;
            // A wrap only consumes a full shadow; a transfer only lands in an empty one.
            if (wrap && pending_full) begin
                duty_active  <= pending;
                pending_full <= 1'b0;
            end else if (duty_valid && !pending_full) begin
                pending      <= duty_in;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_compare.sv
// Bench for pwm_compare (WIDTH=4): vector table, hand corner sequences, and randomized run against a spec-level model.
// Honours PWM_INVERT_EN by flipping the expected idle/active polarity.
module tb_pwm_compare;

`ifdef PWM_INVERT_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count = '0;
    logic       en = 1'b0;
    logic [3:0] duty_in = '0;
    logic       duty_valid = 1'b0;
    logic       duty_ready, pwm_out, period_start, running;

    int checks = 0;
    int errors = 0;

    pwm_compare #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .count(count), .en(en),
        .duty_in(duty_in), .duty_valid(duty_valid), .duty_ready(duty_ready),
        .pwm_out(pwm_out), .period_start(period_start), .running(running)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0=idle 1=armed 2=run 3=drain; pending duty kept in a queue of depth <= 1.
    logic [3:0] m_prev = '0;
    logic [3:0] m_pend[$];
    logic [3:0] m_active = '0;
    int         m_mode = 0;
    logic       m_pwm = INV;
    logic       m_ps = 1'b0;

    task automatic model_step();
        bit         w, level;
        logic [3:0] eff;
        if (reset) begin
            m_prev = 0; m_pend.delete(); m_active = 0; m_mode = 0;
            m_pwm = INV; m_ps = 0;
            return;
        end
        w     = (count < m_prev);
        eff   = (w && m_pend.size() != 0) ? m_pend[0] : m_active;
        level = 0;
        m_ps  = 0;
        if (m_mode == 0) begin
            if (en) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!en) m_mode = 0;
            else if (w) begin m_mode = 2; level = (count < eff); m_ps = 1; end
        end else if (m_mode == 2) begin
            level = (count < eff); m_ps = w;
            if (!en) m_mode = 3;
        end else begin
            if (en) begin m_mode = 2; level = (count < eff); m_ps = w; end
            else if (w) m_mode = 0;
            else level = (count < eff);
        end
        m_pwm = level ^ INV;
        if (w && m_pend.size() != 0) m_active = m_pend.pop_front();
        else if (duty_valid && m_pend.size() == 0) m_pend.push_back(duty_in);
        m_prev = count;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b (t=%0t count=%0d)", name, act, exp, $time, count);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk();
        tick();
        check("pwm_out", pwm_out, m_pwm);
        check("period_start", period_start, m_ps);
        check("running", running, m_mode >= 2);
        check("duty_ready", duty_ready, m_pend.size() == 0);
    endtask

    task automatic do_reset(input int n);
        reset = 1; en = 0; duty_valid = 0; count = 0;
        for (int i = 0; i < n; i++) tick();
        reset = 0;
    endtask

    typedef struct {
        logic [3:0] c;
        logic       e;
        logic       dv;
        logic [3:0] d;
        logic       pwm;
        logic       ps;
        logic       run;
        logic       rdy;
    } vec_t;

    vec_t vt[$];

    function automatic void add(input logic [3:0] c, input logic e, input logic dv, input logic [3:0] d,
                                input logic p, input logic s, input logic r, input logic y);
        vec_t v;
        v.c = c; v.e = e; v.dv = dv; v.d = d; v.pwm = p; v.ps = s; v.run = r; v.rdy = y;
        vt.push_back(v);
    endfunction

    initial begin
        int act_cnt, ps_cnt, wraps;
        bit run_ok;
        logic [3:0] c_old;

        // count, en, valid, duty  ->  pwm, period_start, running, duty_ready (after the edge)
        add(0,  0, 1, 4,  0, 0, 0, 0);
        add(7,  1, 0, 0,  0, 0, 0, 0);
        add(15, 1, 0, 0,  0, 0, 0, 0);
        add(0,  1, 0, 0,  1, 1, 1, 1);
        add(3,  1, 0, 0,  1, 0, 1, 1);
        add(4,  1, 0, 0,  0, 0, 1, 1);
        add(6,  1, 1, 10, 0, 0, 1, 0);
        add(7,  1, 1, 7,  0, 0, 1, 0);
        add(15, 1, 1, 7,  0, 0, 1, 0);
        add(0,  1, 1, 7,  1, 1, 1, 1);
        add(1,  1, 1, 7,  1, 0, 1, 0);
        add(9,  1, 0, 0,  1, 0, 1, 0);
        add(10, 1, 0, 0,  0, 0, 1, 0);
        add(12, 0, 0, 0,  0, 0, 1, 0);
        add(0,  0, 0, 0,  0, 0, 0, 1);
        add(3,  0, 0, 0,  0, 0, 0, 1);

        do_reset(3);
        check("reset pwm_out", pwm_out, INV);
        check("reset period_start", period_start, 1'b0);
        check("reset running", running, 1'b0);
        check("reset duty_ready", duty_ready, 1'b1);

        foreach (vt[i]) begin
            count = vt[i].c; en = vt[i].e; duty_valid = vt[i].dv; duty_in = vt[i].d;
            tick();
            check($sformatf("vec%0d pwm_out", i), pwm_out, vt[i].pwm ^ INV);
            check($sformatf("vec%0d period_start", i), period_start, vt[i].ps);
            check($sformatf("vec%0d running", i), running, vt[i].run);
            check($sformatf("vec%0d duty_ready", i), duty_ready, vt[i].rdy);
        end

        // Duty extremes: four full periods after arming at the first wrap.
        for (int dsel = 0; dsel < 2; dsel++) begin
            do_reset(2);
            act_cnt = 0; ps_cnt = 0;
            for (int i = 1; i < 80; i++) begin
                count = i % 16; en = 1;
                duty_valid = (i == 1); duty_in = (dsel == 0) ? 4'd0 : 4'd15;
                tick_chk();
                if (i >= 16) begin
                    act_cnt += (pwm_out ^ INV);
                    ps_cnt  += period_start;
                end
            end
            checks++;
            if (act_cnt != ((dsel == 0) ? 0 : 60) || ps_cnt != 4) begin
                errors++;
                $display("FAIL duty%0d_periods: active=%0d ps=%0d expected active=%0d ps=4",
                         dsel * 15, act_cnt, ps_cnt, (dsel == 0) ? 0 : 60);
            end
        end

        // Drop en at count 5, reassert at 12 while draining: output never stops.
        run_ok = 1;
        duty_valid = 0;
        for (int i = 80; i < 112; i++) begin
            count = i % 16;
            en = !(i >= 85 && i < 92);
            tick_chk();
            if (!running) run_ok = 0;
        end
        checks++;
        if (!run_ok) begin
            errors++;
            $display("FAIL drain_reenable: running dropped, expected continuous");
        end

        // Increment of 3: every wrap (including 15->2) produces exactly one strobe.
        do_reset(2);
        ps_cnt = 0; wraps = 0; c_old = 0;
        duty_valid = 1; duty_in = 4'd9;
        for (int i = 0; i < 48; i++) begin
            count = c_old + 4'd3; en = 1;
            if (count < c_old) wraps++;
            c_old = count;
            tick_chk();
            duty_valid = 0;
            ps_cnt += period_start;
        end
        checks++;
        if (ps_cnt != wraps || wraps != 9) begin
            errors++;
            $display("FAIL p3_strobes: got %0d strobes for %0d wraps, expected 9", ps_cnt, wraps);
        end

        // Reset mid-operation discards a waiting duty value.
        duty_valid = 1; duty_in = 4'd5; count = c_old + 4'd3;
        tick_chk();
        reset = 1; duty_valid = 0;
        tick_chk();
        reset = 0;
        check("midreset duty_ready", duty_ready, 1'b1);
        check("midreset pwm_out", pwm_out, INV);

        // Randomized traffic with mixed increments and occasional resets.
        count = 0;
        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 23) == 0) en = ~en;
            duty_valid = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: duty_in = 4'd0;
                1: duty_in = 4'd15;
                default: duty_in = 4'($urandom_range(0, 15));
            endcase
            count = count + (((i / 500) % 3 == 0) ? 4'd1 : ((i / 500) % 3 == 1) ? 4'd3 : 4'd5);
            tick_chk();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
